// File: rtl/cic_comb.sv
// -----------------------------------------------------------------------------
// cic_comb
//
// Comb (differentiator) section of a CIC decimator. It takes the decimated
// sample/strobe stream from the rate-reduction stage and runs it through
// CIC_N cascaded comb stages. Each stage computes y[n] = x[n] - x[n-CIC_M]
// with modular two's-complement arithmetic. There is one pipeline register
// per stage, followed by a registered MSB-truncation output stage.
//
// Parameters:
//   DATA_WIDTH_INP : input and internal datapath width (matches the integrators)
//   DATA_WIDTH_OUT : output width, <= DATA_WIDTH_INP; the MSBs are kept
//   CIC_N          : number of comb stages (>= 1)
//   CIC_M          : differential delay in decimated samples (>= 1)
//
// Ports:
//   clk           : system clock, rising edge
//   reset         : asynchronous, active-high reset
//   inp_samp_data : signed decimated input sample
//   inp_samp_str  : one-cycle strobe marking a valid input sample
//   out_samp_data : signed, truncated comb output (held between strobes)
//   out_samp_str  : one-cycle strobe, CIC_N+1 clocks after the input strobe
// -----------------------------------------------------------------------------
module cic_comb #(
  parameter int DATA_WIDTH_INP = 8,
  parameter int DATA_WIDTH_OUT = 8,
  parameter int CIC_N          = 3,
  parameter int CIC_M          = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH_INP-1:0] inp_samp_data,
  input  logic                      inp_samp_str,
  output logic [DATA_WIDTH_OUT-1:0] out_samp_data,
  output logic                      out_samp_str
);

  genvar k;

  // One generate block per comb stage. Stage k takes its sample and valid
  // from stage k-1 (or from the module inputs for the first stage).
  for (k = 0; k < CIC_N; k++) begin : g_stage
    logic [DATA_WIDTH_INP-1:0] x_in;
    logic                      v_in;
    logic [DATA_WIDTH_INP-1:0] stage_q;
    logic                      valid_q;
    logic [DATA_WIDTH_INP-1:0] dly_q [CIC_M];

    if (k == 0) begin : g_first
      assign x_in = inp_samp_data;
      assign v_in = inp_samp_str;
    end else begin : g_chain
      assign x_in = g_stage[k-1].stage_q;
      assign v_in = g_stage[k-1].valid_q;
    end

    // The delay line moves only on valid samples. Idle cycles between
    // strobes therefore do not change the difference being computed.
    // The subtraction wraps at the full datapath width. That wrap is
    // what cancels the integrator overflow, so it must not saturate.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stage_q <= '0;
        valid_q <= 1'b0;
        for (int i = 0; i < CIC_M; i++) begin
          dly_q[i] <= '0;
        end
      end else begin
        valid_q <= v_in;
        if (v_in) begin
          stage_q  <= x_in - dly_q[CIC_M-1];
          dly_q[0] <= x_in;
          for (int i = 1; i < CIC_M; i++) begin
            dly_q[i] <= dly_q[i-1];
          end
        end
      end
    end
  end

  logic [DATA_WIDTH_INP-1:0] last_data;
  logic                      last_valid;

  assign last_data  = g_stage[CIC_N-1].stage_q;
  assign last_valid = g_stage[CIC_N-1].valid_q;

  // Output register. It keeps the top DATA_WIDTH_OUT bits of the last stage
  // and simply drops the LSBs, with no rounding. The data holds between
  // strobes. The strobe follows the last stage valid on every clock, so it
  // lasts exactly one cycle per sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_samp_data <= '0;
      out_samp_str  <= 1'b0;
    end else begin
      out_samp_str <= last_valid;
      if (last_valid) begin
        out_samp_data <= last_data[DATA_WIDTH_INP-1 -: DATA_WIDTH_OUT];
      end
    end
  end

endmodule

// File: tb/tb_cic_comb.sv
// -----------------------------------------------------------------------------
// tb_cic_comb
//
// Drives four cic_comb instances, each with different parameters:
//   comb3  : N=3, M=1, 8/8  (impulse, step, reset mid-stream)
//   comb1  : N=1, M=1, 8/8  (wrap-around)
//   comb2  : N=1, M=2, 8/8  (differential delay with irregular gaps)
//   combT  : N=1, M=1, 12/8 (MSB truncation)
// Each issued sample pushes its hand-computed expected output and expected
// arrival cycle into that instance's queue. A separate monitor per instance
// pops the queue and compares whenever the instance raises its strobe.
// -----------------------------------------------------------------------------
module tb_cic_comb;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  int          cyc = 0;
  int          vectors = 0;
  int          fails = 0;

  logic [7:0]  d3, d1, d2;
  logic [11:0] dT;
  logic        s3, s1, s2, sT;
  logic [7:0]  o3, o1, o2, oT;
  logic        os3, os1, os2, osT;

  exp_t q3[$], q1[$], q2[$], qT[$];
  exp_t e3, e1, e2, eT;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  cic_comb #(.DATA_WIDTH_INP(8), .DATA_WIDTH_OUT(8), .CIC_N(3), .CIC_M(1)) u_comb3 (
    .clk(clk), .reset(reset), .inp_samp_data(d3), .inp_samp_str(s3),
    .out_samp_data(o3), .out_samp_str(os3));

  cic_comb #(.DATA_WIDTH_INP(8), .DATA_WIDTH_OUT(8), .CIC_N(1), .CIC_M(1)) u_comb1 (
    .clk(clk), .reset(reset), .inp_samp_data(d1), .inp_samp_str(s1),
    .out_samp_data(o1), .out_samp_str(os1));

  cic_comb #(.DATA_WIDTH_INP(8), .DATA_WIDTH_OUT(8), .CIC_N(1), .CIC_M(2)) u_comb2 (
    .clk(clk), .reset(reset), .inp_samp_data(d2), .inp_samp_str(s2),
    .out_samp_data(o2), .out_samp_str(os2));

  cic_comb #(.DATA_WIDTH_INP(12), .DATA_WIDTH_OUT(8), .CIC_N(1), .CIC_M(1)) u_combT (
    .clk(clk), .reset(reset), .inp_samp_data(dT), .inp_samp_str(sT),
    .out_samp_data(oT), .out_samp_str(osT));

  // Scoreboard comparison of one emitted sample: data and arrival cycle.
  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp,
                             input int act_cyc, input int exp_cyc);
    vectors++;
    if (act !== exp || act_cyc != exp_cyc) begin
      fails++;
      $display("[TB] FAIL %s: got data 0x%02h at cycle %0d, expected 0x%02h at cycle %0d",
               name, act, act_cyc, exp, exp_cyc);
    end
  endtask

  // Direct comparison of a level, used around reset.
  task automatic checkValue(input string name, input logic [11:0] act, input logic [11:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%03h, expected 0x%03h", name, act, exp);
    end
  endtask

  task automatic unexpectedStrobe(input string name, input logic [7:0] act);
    vectors++;
    fails++;
    $display("[TB] FAIL %s: unexpected strobe with data 0x%02h at cycle %0d", name, act, cyc);
  endtask

  // Issues one sample to the selected instance and optionally records its
  // expected output. The task is entered 1ns after a rising edge. It leaves
  // the strobe high for one clock, then idles for the requested number of clocks.
  task automatic applyStimulus(input int sel, input logic [11:0] data, input logic [7:0] exp,
                               input bit push, input int idles);
    exp_t e;
    e.data = exp;
    e.cyc  = cyc + ((sel == 0) ? 4 : 2);
    case (sel)
      0: begin d3 = data[7:0]; s3 = 1'b1; if (push) q3.push_back(e); end
      1: begin d1 = data[7:0]; s1 = 1'b1; if (push) q1.push_back(e); end
      2: begin d2 = data[7:0]; s2 = 1'b1; if (push) q2.push_back(e); end
      default: begin dT = data; sT = 1'b1; if (push) qT.push_back(e); end
    endcase
    @(posedge clk);
    #1;
    s3 = 1'b0; s1 = 1'b0; s2 = 1'b0; sT = 1'b0;
    repeat (idles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitors: sample the outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (os3) begin
      if (q3.size() == 0) unexpectedStrobe("comb3", o3);
      else begin e3 = q3.pop_front(); checkOutput("comb3", o3, e3.data, cyc, e3.cyc); end
    end
  end

  always @(negedge clk) begin
    if (os1) begin
      if (q1.size() == 0) unexpectedStrobe("comb1", o1);
      else begin e1 = q1.pop_front(); checkOutput("comb1", o1, e1.data, cyc, e1.cyc); end
    end
  end

  always @(negedge clk) begin
    if (os2) begin
      if (q2.size() == 0) unexpectedStrobe("comb2", o2);
      else begin e2 = q2.pop_front(); checkOutput("comb2", o2, e2.data, cyc, e2.cyc); end
    end
  end

  always @(negedge clk) begin
    if (osT) begin
      if (qT.size() == 0) unexpectedStrobe("combT", oT);
      else begin eT = qT.pop_front(); checkOutput("combT", oT, eT.data, cyc, eT.cyc); end
    end
  end

  initial begin
    reset = 1'b1;
    d3 = '0; d1 = '0; d2 = '0; dT = '0;
    s3 = 1'b0; s1 = 1'b0; s2 = 1'b0; sT = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkValue("reset comb3 data", {4'h0, o3}, 12'h000);
    checkValue("reset comb3 str", {11'h0, os3}, 12'h000);
    checkValue("reset combT data", {4'h0, oT}, 12'h000);
    checkValue("reset comb2 str", {11'h0, os2}, 12'h000);
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] impulse N=3 M=1, strobe every 4th clock");
    applyStimulus(0, 12'h001, 8'h01, 1'b1, 3);
    applyStimulus(0, 12'h000, 8'hFD, 1'b1, 3);
    applyStimulus(0, 12'h000, 8'h03, 1'b1, 3);
    applyStimulus(0, 12'h000, 8'hFF, 1'b1, 3);
    applyStimulus(0, 12'h000, 8'h00, 1'b1, 6);

    $display("[TB] step N=3 M=1, back-to-back strobes");
    applyStimulus(0, 12'h001, 8'h01, 1'b1, 0);
    applyStimulus(0, 12'h001, 8'hFE, 1'b1, 0);
    applyStimulus(0, 12'h001, 8'h01, 1'b1, 0);
    applyStimulus(0, 12'h001, 8'h00, 1'b1, 0);
    applyStimulus(0, 12'h001, 8'h00, 1'b1, 6);

    $display("[TB] wrap-around N=1 M=1");
    applyStimulus(1, 12'h07F, 8'h7F, 1'b1, 1);
    applyStimulus(1, 12'h080, 8'h01, 1'b1, 3);

    $display("[TB] differential delay N=1 M=2 with irregular gaps");
    applyStimulus(2, 12'h000, 8'h00, 1'b1, 0);
    applyStimulus(2, 12'h001, 8'h01, 1'b1, 5);
    applyStimulus(2, 12'h002, 8'h02, 1'b1, 2);
    applyStimulus(2, 12'h003, 8'h02, 1'b1, 0);
    applyStimulus(2, 12'h004, 8'h02, 1'b1, 4);

    $display("[TB] truncation 12 -> 8 bits");
    applyStimulus(3, 12'h7F0, 8'h7F, 1'b1, 1);
    applyStimulus(3, 12'h000, 8'h81, 1'b1, 2);
    applyStimulus(3, 12'h80F, 8'h80, 1'b1, 4);

    $display("[TB] reset mid-stream N=3 M=1");
    // After the step the stage-1 delay holds 1, so 7 produces 6 at the output.
    applyStimulus(0, 12'h007, 8'h06, 1'b1, 6);
    applyStimulus(0, 12'h011, 8'h00, 1'b0, 0);
    applyStimulus(0, 12'h022, 8'h00, 1'b0, 0);
    #2;
    reset = 1'b1;
    #1;
    checkValue("mid-reset comb3 data", {4'h0, o3}, 12'h000);
    checkValue("mid-reset comb3 str", {11'h0, os3}, 12'h000);
    // Strobe while reset is held must be ignored.
    applyStimulus(0, 12'h044, 8'h00, 1'b0, 2);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end

    $display("[TB] impulse of 5 after reset");
    applyStimulus(0, 12'h005, 8'h05, 1'b1, 3);
    applyStimulus(0, 12'h000, 8'hF1, 1'b1, 3);
    applyStimulus(0, 12'h000, 8'h0F, 1'b1, 3);
    applyStimulus(0, 12'h000, 8'hFB, 1'b1, 3);

    repeat (10) @(posedge clk);
    #1;
    checkValue("comb3 pending", 12'(q3.size()), 12'h000);
    checkValue("comb1 pending", 12'(q1.size()), 12'h000);
    checkValue("comb2 pending", 12'(q2.size()), 12'h000);
    checkValue("combT pending", 12'(qT.size()), 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
